// File: rtl/display_pkg.sv
// display_pkg: types and constants shared by run_timer and the seven-segment display driver
package display_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} timer_state_t;
    localparam int DISP_MAX         = 9999;
    localparam int CLK_TICKS_PER_MS = 100000;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that emits a single-cycle tick once every TICKS_PER_UNIT enabled cycles
//   clk, rst  : clock and synchronous active-high reset
//   en        : advance the prescaler this cycle
//   sync_clr  : zero the prescaler (wins over en)
//   tick      : high while the prescaler sits at TICKS_PER_UNIT-1 and is enabled
module tick_gen #(
    parameter int TICKS_PER_UNIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int W = $clog2(TICKS_PER_UNIT);
    logic [W-1:0] cnt_q;
    assign tick = en && cnt_q == W'(TICKS_PER_UNIT - 1);
    always_ff @(posedge clk) begin
        if (rst || sync_clr) cnt_q <= '0;
        else if (en)         cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/run_timer.sv
// run_timer: measures one job's run time in units, freezes on done, saturates at MAX_COUNT
//   clk, rst  : clock and synchronous active-high reset
//   start     : begin or restart a run (zeroes counters and overflow)
//   done      : end a run, value freezes
//   clear     : return to idle with a zero count
//   data_seg  : elapsed units, zero-extended for the display driver
//   running   : high while a run is in progress
//   overflow  : sticky, a tick arrived while the count was already at MAX_COUNT
module run_timer
    import display_pkg::*;
#(
    parameter int TICKS_PER_UNIT = CLK_TICKS_PER_MS,
    parameter int MAX_COUNT      = DISP_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        done,
    input  logic        clear,
    output logic [31:0] data_seg,
    output logic        running,
    output logic        overflow
);
    localparam int CNT_W = $clog2(MAX_COUNT + 1);
    timer_state_t     state_q;
    logic [CNT_W-1:0] elapsed_q;
    logic             overflow_q;
    logic             tick;
    // start and clear both restart the unit phase from zero
    tick_gen #(.TICKS_PER_UNIT(TICKS_PER_UNIT)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == RUN),
        .sync_clr (clear || start),
        .tick     (tick)
    );
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q    <= IDLE;
            elapsed_q  <= '0;
            overflow_q <= 1'b0;
        end else if (start) begin
            state_q    <= RUN;
            elapsed_q  <= '0;
            overflow_q <= 1'b0;
        end else if (state_q == RUN) begin
            // a tick landing on the done edge is still counted
            if (tick) begin
                if (elapsed_q == CNT_W'(MAX_COUNT)) overflow_q <= 1'b1;
                else                                elapsed_q  <= elapsed_q + 1'b1;
            end
            if (done) state_q <= HOLD;
        end
    end
    assign data_seg = 32'(elapsed_q);
    assign running  = state_q == RUN;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_run_timer.sv
// tb_run_timer: directed checks of run_timer with TICKS_PER_UNIT=4, MAX_COUNT=9
module tb_run_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] data_seg;
    logic        running;
    logic        overflow;
    int          n_checks = 0;
    int          n_fails = 0;

    run_timer #(.TICKS_PER_UNIT(4), .MAX_COUNT(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .done     (done),
        .clear    (clear),
        .data_seg (data_seg),
        .running  (running),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic outs(input string tag, input int d, input logic r, input logic o);
        check({tag, ".data"}, data_seg, 32'(d));
        check({tag, ".run"}, 32'(running), 32'(r));
        check({tag, ".ovf"}, 32'(overflow), 32'(o));
    endtask

    task automatic pulse(input logic s, input logic d, input logic c);
        start = s; done = d; clear = c;
        step();
        start = 0; done = 0; clear = 0;
    endtask

    initial begin
        step(2);
        rst = 0;
        outs("reset", 0, 0, 0);
        // basic run and hold
        pulse(1, 0, 0);
        outs("t1.e0", 0, 1, 0);
        step(3);  check("t1.e3", data_seg, 0);
        step(1);  check("t1.e4", data_seg, 1);
        step(4);  check("t1.e8", data_seg, 2);
        step(4);  check("t1.e12", data_seg, 3);
        step(1);
        pulse(0, 1, 0);
        outs("t1.e14", 3, 0, 0);
        step(20);
        outs("t1.held", 3, 0, 0);
        // done and clear in HOLD
        pulse(0, 1, 0);
        outs("t5.done_hold", 3, 0, 0);
        pulse(0, 0, 1);
        outs("t5.clear_hold", 0, 0, 0);
        // done in IDLE
        pulse(0, 1, 0);
        outs("t5.done_idle", 0, 0, 0);
        step(8);
        outs("t5.idle_wait", 0, 0, 0);
        // saturation
        pulse(1, 0, 0);
        step(35); outs("t2.e35", 8, 1, 0);
        step(1);  outs("t2.e36", 9, 1, 0);
        step(3);  outs("t2.e39", 9, 1, 0);
        step(1);  outs("t2.e40", 9, 1, 1);
        step(20); outs("t2.e60", 9, 1, 1);
        // restart mid-run clears overflow
        pulse(1, 0, 0);
        step(8);  check("t3.e8", data_seg, 2);
        pulse(1, 0, 0);
        outs("t3.e9", 0, 1, 0);
        step(3);  check("t3.e12", data_seg, 0);
        step(1);  check("t3.e13", data_seg, 1);
        // start+done in RUN restarts
        pulse(1, 1, 0);
        outs("t4.sd", 0, 1, 0);
        step(3);  check("t4.sd.e3", data_seg, 0);
        step(1);  check("t4.sd.e4", data_seg, 1);
        // clear+start goes to IDLE
        pulse(1, 0, 1);
        outs("t4.cs_run", 0, 0, 0);
        pulse(1, 0, 1);
        outs("t4.cs_idle", 0, 0, 0);
        step(6);
        outs("t4.cs_wait", 0, 0, 0);
        // done on the tick edge
        pulse(1, 0, 0);
        step(7);
        check("t4.e7", data_seg, 1);
        pulse(0, 1, 0);
        outs("t4.done_tick", 2, 0, 0);
        step(8);
        outs("t4.done_tick.held", 2, 0, 0);
        // restart from HOLD
        pulse(1, 0, 0);
        outs("t4.hold_start", 0, 1, 0);
        // reset mid-run
        pulse(1, 0, 0);
        step(9);
        check("t6.e9", data_seg, 2);
        rst = 1;
        step(1);
        rst = 0;
        outs("t6.e10", 0, 0, 0);
        step(10);
        outs("t6.after", 0, 0, 0);
        pulse(1, 0, 0);
        step(4);
        outs("t6.restart", 1, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
